// File: rtl/lcd_3wire_slave_if.sv
// Host-side register access port of the 3-wire LCD responder.
// Carries the side-port read path and the write/error notifications.
interface lcd_3wire_slave_if;
   logic [5:0] iRD_ADDR;
   logic [7:0] oRD_DATA;
   logic       oWR_STB;
   logic [5:0] oWR_ADDR;
   logic [7:0] oWR_DATA;
   logic       oFRAME_ERR;

   modport slave (
      input  iRD_ADDR,
      output oRD_DATA, oWR_STB, oWR_ADDR, oWR_DATA, oFRAME_ERR
   );

   modport master (
      output iRD_ADDR,
      input  oRD_DATA, oWR_STB, oWR_ADDR, oWR_DATA, oFRAME_ERR
   );
endinterface

// File: rtl/lcd_3wire_slave.sv
// Panel-side responder for the 3-wire LCD config link (SCEN/SCLK/SDAT, 16-bit frames).
// The link is oversampled in the iCLK domain; frames are [15:10] addr, [9] R/W (1=read),
// [8] reserved, [7:0] data, MSB first, captured on SCLK rising edges.
module lcd_3wire_slave #(
   parameter int REG_COUNT   = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                iCLK,
   input  logic                iRST_N,
   input  logic                I2S_SCLK,
   input  logic                I2S_SCEN,
   inout  wire                 I2S_SDAT,
   lcd_3wire_slave_if.slave    host
);

   localparam int AW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
   localparam logic [6:0] REG_LIM = 7'(REG_COUNT);

   typedef enum logic [2:0] {IDLE, HDR, WDATA, RDATA, DONE} state_t;

   logic [SYNC_STAGES-1:0] sclk_sync, scen_sync, sdat_sync;
   logic                   sclk_prev, scen_prev;
   logic                   sclk_s, scen_s, sdat_s;
   logic                   sclk_rise, sclk_fall, scen_rise, scen_fall;

   state_t     state, state_nxt;
   logic [4:0] cnt;
   logic [7:0] shreg, shift_in, tx;
   logic [5:0] addr;
   logic       go_hdr, hdr_done, load_tx, commit, abort;
   logic       sdat_oe;

   logic [7:0] regs [REG_COUNT];

   // Out-of-range addresses read back as zero.
   function automatic logic [7:0] reg_rd(input logic [5:0] a);
      if ({1'b0, a} < REG_LIM) return regs[a[AW-1:0]];
      return 8'h00;
   endfunction

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign scen_s    = scen_sync[SYNC_STAGES-1];
   assign sdat_s    = sdat_sync[SYNC_STAGES-1];
   assign sclk_rise =  sclk_s & ~sclk_prev;
   assign sclk_fall = ~sclk_s &  sclk_prev;
   assign scen_rise =  scen_s & ~scen_prev;
   assign scen_fall = ~scen_s &  scen_prev;
   assign shift_in  = {shreg[6:0], sdat_s};

   // Link synchronizers; SCEN resets high so leaving reset is not seen as a frame start.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         sclk_sync <= '0;
         scen_sync <= '1;
         sdat_sync <= '0;
         sclk_prev <= 1'b0;
         scen_prev <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], I2S_SCLK};
         scen_sync <= {scen_sync[SYNC_STAGES-2:0], I2S_SCEN};
         sdat_sync <= {sdat_sync[SYNC_STAGES-2:0], I2S_SDAT};
         sclk_prev <= sclk_s;
         scen_prev <= scen_s;
      end
   end

   // Frame state register.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next-state and datapath strobes; a SCEN fall always restarts the frame.
   always_comb begin
      state_nxt = state;
      go_hdr    = 1'b0;
      hdr_done  = 1'b0;
      load_tx   = 1'b0;
      commit    = 1'b0;
      abort     = 1'b0;
      if (scen_fall) begin
         state_nxt = HDR;
         go_hdr    = 1'b1;
      end else if (scen_rise) begin
         state_nxt = IDLE;
         abort     = (state == HDR) || (state == WDATA) || (state == RDATA);
      end else begin
         case (state)
            HDR: if (sclk_rise && cnt == 5'd7) begin
               hdr_done = 1'b1;
               if (shift_in[1]) begin
                  state_nxt = RDATA;
                  load_tx   = 1'b1;
               end else begin
                  state_nxt = WDATA;
               end
            end
            WDATA: if (sclk_rise && cnt == 5'd15) begin
               state_nxt = DONE;
               commit    = 1'b1;
            end
            RDATA: if (sclk_rise && cnt == 5'd15) state_nxt = DONE;
            default: ;
         endcase
      end
   end

   // Bit counter, receive shifter, latched address and readback shifter.
   // The fall right after the 8th rise must not shift: bit7 has to survive to the 9th rise.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         cnt   <= '0;
         shreg <= '0;
         addr  <= '0;
         tx    <= '0;
      end else begin
         if (go_hdr) begin
            cnt   <= '0;
            shreg <= '0;
         end else if (sclk_rise && (state == HDR || state == WDATA || state == RDATA)) begin
            cnt   <= cnt + 5'd1;
            shreg <= shift_in;
         end
         if (hdr_done) addr <= shift_in[7:2];
         if (load_tx)
            tx <= reg_rd(shift_in[7:2]);
         else if (state == RDATA && sclk_fall && cnt > 5'd8)
            tx <= {tx[6:0], 1'b0};
      end
   end

   // Register file write from committed serial frames.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         for (int i = 0; i < REG_COUNT; i++) regs[i] <= 8'h00;
      end else if (commit && ({1'b0, addr} < REG_LIM)) begin
         regs[addr[AW-1:0]] <= shift_in;
      end
   end

   // Host-visible registered outputs: read port, write notification, abort pulse.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         host.oRD_DATA   <= 8'h00;
         host.oWR_STB    <= 1'b0;
         host.oWR_ADDR   <= 6'h00;
         host.oWR_DATA   <= 8'h00;
         host.oFRAME_ERR <= 1'b0;
      end else begin
         host.oRD_DATA   <= reg_rd(host.iRD_ADDR);
         host.oWR_STB    <= commit;
         host.oFRAME_ERR <= abort;
         if (commit) begin
            host.oWR_ADDR <= addr;
            host.oWR_DATA <= shift_in;
         end
      end
   end

   assign sdat_oe  = (state == RDATA) && iRST_N;
   assign I2S_SDAT = sdat_oe ? tx[7] : 1'bz;

endmodule

// File: tb/tb_lcd_3wire_slave.sv
// Directed bench for lcd_3wire_slave: serial write/read frames, aborts, overrun clocks,
// out-of-range addresses, host-port collision and reset during readback.
module tb_lcd_3wire_slave;

   localparam int HALF = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sclk = 1'b0;
   logic scen = 1'b1;
   logic drv_en = 1'b0;
   logic drv_val = 1'b0;
   wire  sdat;

   int n_chk = 0;
   int n_fail = 0;
   int stb_cnt = 0;
   int err_cnt = 0;
   logic [7:0] stb_rd_now, stb_rd_next;
   logic grab_next = 1'b0;

   lcd_3wire_slave_if host ();

   assign sdat = drv_en ? drv_val : 1'bz;

   lcd_3wire_slave dut (
      .iCLK     (clk),
      .iRST_N   (rst_n),
      .I2S_SCLK (sclk),
      .I2S_SCEN (scen),
      .I2S_SDAT (sdat),
      .host     (host)
   );

   always #5 clk = ~clk;

   // Pulse counters, plus host read data seen on the strobe cycle and the one after.
   always @(negedge clk) begin
      if (host.oWR_STB) begin
         stb_cnt++;
         stb_rd_now = host.oRD_DATA;
         grab_next = 1'b1;
      end else if (grab_next) begin
         stb_rd_next = host.oRD_DATA;
         grab_next = 1'b0;
      end
      if (host.oFRAME_ERR) err_cnt++;
   end

   task automatic bit_cycle(input logic v, input logic drv, output logic smp);
      drv_en = drv;
      drv_val = v;
      repeat (HALF) @(negedge clk);
      smp = sdat;
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
   endtask

   task automatic xfer(input logic [15:0] frm, input int nbits, input logic rd, output logic [7:0] rx);
      logic smp, b;
      rx = 8'h00;
      scen = 1'b0;
      repeat (HALF) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         b = (i < 16) ? frm[15-i] : 1'b0;
         bit_cycle(b, !(rd && i >= 8), smp);
         if (rd && i >= 8 && i < 16) rx = {rx[6:0], smp};
      end
      drv_en = 1'b0;
      repeat (HALF) @(negedge clk);
      scen = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic host_rd(input logic [5:0] a, output logic [7:0] d);
      host.iRD_ADDR = a;
      @(negedge clk);
      @(negedge clk);
      d = host.oRD_DATA;
   endtask

   task automatic clr_cnt();
      stb_cnt = 0;
      err_cnt = 0;
   endtask

   task automatic test_reset();
      logic [7:0] d;
      host.iRD_ADDR = 6'd0;
      rst_n = 1'b0;
      repeat (4) @(negedge clk);
      n_chk++; if (dut.sdat_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe_in_reset: got %0h exp 0", dut.sdat_oe); end
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      n_chk++; if (host.oWR_STB !== 1'b0) begin n_fail++; $display("FAIL reset_stb: got %0h exp 0", host.oWR_STB); end
      n_chk++; if (host.oFRAME_ERR !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0h exp 0", host.oFRAME_ERR); end
      n_chk++; if (host.oWR_ADDR !== 6'h00) begin n_fail++; $display("FAIL reset_wr_addr: got %0h exp 0", host.oWR_ADDR); end
      n_chk++; if (host.oWR_DATA !== 8'h00) begin n_fail++; $display("FAIL reset_wr_data: got %0h exp 0", host.oWR_DATA); end
      n_chk++; if (dut.sdat_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %0h exp 0", dut.sdat_oe); end
      host_rd(6'd3, d);
      n_chk++; if (d !== 8'h00) begin n_fail++; $display("FAIL reset_reg3: got %0h exp 0", d); end
   endtask

   task automatic test_write();
      logic [7:0] rx, d;
      clr_cnt();
      xfer(16'h0C01, 16, 1'b0, rx);
      n_chk++; if (stb_cnt !== 1) begin n_fail++; $display("FAIL write_stb_cnt: got %0d exp 1", stb_cnt); end
      n_chk++; if (err_cnt !== 0) begin n_fail++; $display("FAIL write_err_cnt: got %0d exp 0", err_cnt); end
      n_chk++; if (host.oWR_ADDR !== 6'd3) begin n_fail++; $display("FAIL write_addr: got %0h exp 3", host.oWR_ADDR); end
      n_chk++; if (host.oWR_DATA !== 8'h01) begin n_fail++; $display("FAIL write_data: got %0h exp 1", host.oWR_DATA); end
      host_rd(6'd3, d);
      n_chk++; if (d !== 8'h01) begin n_fail++; $display("FAIL write_readback: got %0h exp 1", d); end
   endtask

   task automatic test_read();
      logic [7:0] rx;
      clr_cnt();
      xfer(16'h103F, 16, 1'b0, rx);
      xfer(16'h1200, 16, 1'b1, rx);
      n_chk++; if (rx !== 8'h3F) begin n_fail++; $display("FAIL read_sdat: got %0h exp 3f", rx); end
      n_chk++; if (stb_cnt !== 1) begin n_fail++; $display("FAIL read_stb_cnt: got %0d exp 1", stb_cnt); end
      n_chk++; if (err_cnt !== 0) begin n_fail++; $display("FAIL read_err_cnt: got %0d exp 0", err_cnt); end
      n_chk++; if (dut.sdat_oe !== 1'b0) begin n_fail++; $display("FAIL read_oe_after: got %0h exp 0", dut.sdat_oe); end
      xfer(16'h0E00, 16, 1'b1, rx);
      n_chk++; if (rx !== 8'h01) begin n_fail++; $display("FAIL read_addr3: got %0h exp 1", rx); end
   endtask

   task automatic test_abort();
      logic [7:0] rx, d;
      clr_cnt();
      xfer(16'h140F, 11, 1'b0, rx);
      n_chk++; if (err_cnt !== 1) begin n_fail++; $display("FAIL abort_err_cnt: got %0d exp 1", err_cnt); end
      n_chk++; if (stb_cnt !== 0) begin n_fail++; $display("FAIL abort_stb_cnt: got %0d exp 0", stb_cnt); end
      host_rd(6'd5, d);
      n_chk++; if (d !== 8'h00) begin n_fail++; $display("FAIL abort_reg5: got %0h exp 0", d); end
   endtask

   task automatic test_extra_clocks();
      logic [7:0] rx, d;
      clr_cnt();
      host.iRD_ADDR = 6'd5;
      xfer(16'h140F, 20, 1'b0, rx);
      n_chk++; if (stb_cnt !== 1) begin n_fail++; $display("FAIL extra_stb_cnt: got %0d exp 1", stb_cnt); end
      n_chk++; if (err_cnt !== 0) begin n_fail++; $display("FAIL extra_err_cnt: got %0d exp 0", err_cnt); end
      n_chk++; if (stb_rd_now !== 8'h00) begin n_fail++; $display("FAIL collide_old: got %0h exp 0", stb_rd_now); end
      n_chk++; if (stb_rd_next !== 8'h0F) begin n_fail++; $display("FAIL collide_new: got %0h exp f", stb_rd_next); end
      host_rd(6'd5, d);
      n_chk++; if (d !== 8'h0F) begin n_fail++; $display("FAIL extra_reg5: got %0h exp f", d); end
   endtask

   task automatic test_out_of_range();
      logic [7:0] rx, d;
      clr_cnt();
      xfer(16'hA0AA, 16, 1'b0, rx);
      n_chk++; if (stb_cnt !== 1) begin n_fail++; $display("FAIL oor_stb_cnt: got %0d exp 1", stb_cnt); end
      n_chk++; if (host.oWR_ADDR !== 6'd40) begin n_fail++; $display("FAIL oor_wr_addr: got %0d exp 40", host.oWR_ADDR); end
      n_chk++; if (host.oWR_DATA !== 8'hAA) begin n_fail++; $display("FAIL oor_wr_data: got %0h exp aa", host.oWR_DATA); end
      host_rd(6'd40, d);
      n_chk++; if (d !== 8'h00) begin n_fail++; $display("FAIL oor_readback: got %0h exp 0", d); end
      host_rd(6'd8, d);
      n_chk++; if (d !== 8'h00) begin n_fail++; $display("FAIL oor_alias8: got %0h exp 0", d); end
      xfer(16'hA200, 16, 1'b1, rx);
      n_chk++; if (rx !== 8'h00) begin n_fail++; $display("FAIL oor_serial_read: got %0h exp 0", rx); end
   endtask

   task automatic test_reset_mid_read();
      logic [7:0] rx, d;
      logic [15:0] f;
      logic smp;
      xfer(16'h0C55, 16, 1'b0, rx);
      f = 16'h0E00;
      scen = 1'b0;
      repeat (HALF) @(negedge clk);
      for (int i = 0; i < 10; i++) bit_cycle(f[15-i], i < 8, smp);
      n_chk++; if (dut.sdat_oe !== 1'b1) begin n_fail++; $display("FAIL midread_oe: got %0h exp 1", dut.sdat_oe); end
      rst_n = 1'b0;
      #1;
      n_chk++; if (dut.sdat_oe !== 1'b0) begin n_fail++; $display("FAIL rst_release_sdat: got %0h exp 0", dut.sdat_oe); end
      scen = 1'b1;
      sclk = 1'b0;
      drv_en = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      host_rd(6'd3, d);
      n_chk++; if (d !== 8'h00) begin n_fail++; $display("FAIL rst_reg3: got %0h exp 0", d); end
      host_rd(6'd4, d);
      n_chk++; if (d !== 8'h00) begin n_fail++; $display("FAIL rst_reg4: got %0h exp 0", d); end
      clr_cnt();
      xfer(16'h0C01, 16, 1'b0, rx);
      n_chk++; if (stb_cnt !== 1) begin n_fail++; $display("FAIL post_rst_stb: got %0d exp 1", stb_cnt); end
      n_chk++; if (err_cnt !== 0) begin n_fail++; $display("FAIL post_rst_err: got %0d exp 0", err_cnt); end
      host_rd(6'd3, d);
      n_chk++; if (d !== 8'h01) begin n_fail++; $display("FAIL post_rst_reg3: got %0h exp 1", d); end
   endtask

   initial begin
      host.iRD_ADDR = 6'd0;
      test_reset();
      test_write();
      test_read();
      test_abort();
      test_extra_clocks();
      test_out_of_range();
      test_reset_mid_read();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
